boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Sequencer that owns the CPU's program ROM and reset/run lifecycle. It accepts a byte stream from the host, packs bytes into 32-bit little-endian words and writes them into the ROM. It zero-fills any unloaded words, holds the CPU in reset for a fixed number of cycles, then enables the CPU clock. While the CPU runs, it monitors the instruction pointer and halts the CPU when `ip` leaves the ROM. It sits between the host byte channel and the Driver/ROM pair, replacing ad-hoc file loading and bounds checks.

## Interface

Parameters:
- `ROM_SIZE`, 256: ROM depth in 32-bit words; power of two, ≥ 2.
- `RESET_HOLD`, 2: cycles `cpu_rstn` is held low before run; ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `restart`  in  1  single-cycle request to abort and reload from address 0.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_last`  in  1  marks the final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `rom_we`  out  1  ROM write strobe.
- `rom_waddr`  out  $clog2(ROM_SIZE)  ROM write word address.
- `rom_wdata`  out  32  ROM write data.
- `ip`  in  16  CPU instruction pointer (word index).
- `cpu_rstn`  out  1  active-low reset to the CPU.
- `cpu_clk_en`  out  1  CPU clock enable.
- `halted`  out  1  set when `ip` is out of range.
- `halt_ip`  out  16  `ip` value captured at halt.

## Operation

- States:
  - S_LOAD: `in_ready`=1. Accepted bytes fill the word LSB-first; the first byte goes to [7:0] and the fourth to [31:24].
    - A word completes on the 4th byte, or on an `in_last` byte. Bytes not received are zero.
    - On completion the next cycle drives `rom_we`=1 with `rom_waddr`=word index and `rom_wdata`=word. The word index then increments.
    - After the write of the word carrying `in_last`, go to S_FILL. After the write of word ROM_SIZE-1 without `in_last`, go to S_HOLD.
    - In the cycle word ROM_SIZE-1 completes, `in_ready` drops. It stays 0 outside S_LOAD.
  - S_FILL: one zero write per cycle at the next address until address ROM_SIZE-1 is written, then go to S_HOLD. If the loaded words already reach ROM_SIZE, skip S_FILL.
  - S_HOLD: `cpu_rstn`=0 for exactly RESET_HOLD cycles, then go to S_RUN.
  - S_RUN: `cpu_rstn`=1 and `cpu_clk_en`=1. When the sampled `ip` is ≥ ROM_SIZE (unsigned, 16-bit compare), go to S_HALT and capture `halt_ip`.
  - S_HALT: `cpu_clk_en`=0, `cpu_rstn`=1, `halted`=1. Stays here until `rst` or `restart`.
- `restart` in any state: next cycle enters S_LOAD. The byte counter, word index and partial word are cleared, `halted` is cleared, and `cpu_rstn`=0. `restart` overrides a coincident byte accept and pending write; that byte is dropped.
- Priority: `rst` > `restart` > FSM.
- `cpu_rstn` is 0 in S_LOAD, S_FILL and S_HOLD.
- `ip` is ignored outside S_RUN.

## Timing

- Reset values, asserted immediately on `rst`:
  - state S_LOAD; all counters 0.
  - Outputs: `in_ready`=1 (decoded from state), `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `cpu_rstn`=0, `cpu_clk_en`=0, `halted`=0, `halt_ip`=0.
- All outputs except `in_ready` are registered.
- Byte-to-write latency: 1 cycle after the completing byte is accepted.
- Full load with `in_valid` held high: 4·ROM_SIZE accept cycles. The final write follows 1 cycle later, then RESET_HOLD cycles of hold, then `cpu_clk_en` rises.
- Halt: `ip` out of range is sampled at edge N. `halted`, `halt_ip` and `cpu_clk_en`=0 are all visible after edge N. The CPU gets no further enabled cycle.
- Gaps in `in_valid` stall packing without loss. There is no timeout.

## Structure

- Package `boot_pkg`:
  - `boot_state_t` enum {S_LOAD, S_FILL, S_HOLD, S_RUN, S_HALT}.
  - Default constants for ROM_SIZE and RESET_HOLD.
- Sub-module `byte_packer`:
  - 2-bit byte counter plus 32-bit shift/assemble register.
  - Outputs `word_done` and `word`.
  - Handles `in_last` zero padding.
  - Clears on `restart`.
- The FSM, address counter, hold counter and ip comparator live in `boot_sequencer`.

## Test plan

- ROM_SIZE=4, bytes 0x01..0x10 back-to-back, no `in_last` → writes 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3. Then `cpu_rstn`=0 for 2 cycles, then `cpu_rstn`=1 and `cpu_clk_en`=1.
- ROM_SIZE=4, bytes AA BB CC DD EE FF with `in_last` on FF → 0xDDCCBBAA@0, 0x0000FFEE@1, 0@2, 0@3 on consecutive cycles, then hold.
- Same 16 bytes as the first test with `in_valid` toggling every other cycle → identical writes; no byte is lost or duplicated.
- In S_RUN, drive `ip`=3 → no halt. Then drive `ip`=4 → `halted`=1, `halt_ip`=4 and `cpu_clk_en`=0 after that edge; state remains S_HALT for 20 cycles.
- `restart` after 5 bytes accepted → next word write is at address 0 with freshly packed data; `cpu_rstn` stays 0 until the new load completes.
- Assert `rst` asynchronously mid-S_RUN between clock edges → `cpu_rstn`=0, `cpu_clk_en`=0 and `in_ready`=1 without a clock edge.

Source files
------------

// File: rtl/boot_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_pkg
// Purpose  : Shared state encoding and default sizing for the boot sequencer.
// Revision : 1.0
// ============================================================================
package boot_pkg;

    localparam int ROM_SIZE_DEFAULT   = 256;
    localparam int RESET_HOLD_DEFAULT = 2;

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_FILL = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/boot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : boot_sequencer_if
// Purpose  : Host byte channel, ROM write port and CPU control bundle.
// Revision : 1.0
// ============================================================================
interface boot_sequencer_if
    import boot_pkg::*;
#(
    parameter int ROM_SIZE = ROM_SIZE_DEFAULT
);
    localparam int ADDR_W = $clog2(ROM_SIZE);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic [15:0]       ip;
    logic              cpu_rstn;
    logic              cpu_clk_en;
    logic              halted;
    logic [15:0]       halt_ip;

    modport master (
        output in_valid, in_data, in_last, ip,
        input  in_ready, rom_we, rom_waddr, rom_wdata,
               cpu_rstn, cpu_clk_en, halted, halt_ip
    );

    modport slave (
        input  in_valid, in_data, in_last, ip,
        output in_ready, rom_we, rom_waddr, rom_wdata,
               cpu_rstn, cpu_clk_en, halted, halt_ip
    );

endinterface
`default_nettype wire

// File: rtl/boot_sequencer_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs host bytes LSB-first into 32-bit words, zero padding on last.
// Revision : 1.0
// ============================================================================
module byte_packer
    import boot_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        restart,
    input  wire logic        accept,
    input  wire logic [7:0]  in_data,
    input  wire logic        in_last,
    output logic             word_done,
    output logic             word_last,
    output logic [31:0]      word
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] partial_q;
    logic [31:0] partial_d;

    // The partial register is cleared after every word, so the bytes above
    // the current slot are already zero when a word ends early on in_last.
    always_comb begin
        word                       = partial_q;
        word[{cnt_q, 3'b000} +: 8] = in_data;
        word_done                  = accept && ((cnt_q == 2'd3) || in_last);
        word_last                  = accept && in_last;
        cnt_d                      = cnt_q;
        partial_d                  = partial_q;
        if (restart) begin
            cnt_d     = 2'd0;
            partial_d = '0;
        end else if (accept) begin
            if (word_done) begin
                cnt_d     = 2'd0;
                partial_d = '0;
            end else begin
                cnt_d     = cnt_q + 2'd1;
                partial_d = word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 2'd0;
            partial_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : boot_sequencer
// Purpose  : Loads the CPU program ROM from a host byte stream, then runs the
//            CPU and halts it when the instruction pointer leaves the ROM.
// Revision : 1.0
// ============================================================================
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int ROM_SIZE   = ROM_SIZE_DEFAULT,
    parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       restart,
    boot_sequencer_if.slave bus
);

    localparam int                ADDR_W    = $clog2(ROM_SIZE);
    localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD);
    localparam logic [16:0]       IP_LIMIT  = 17'(ROM_SIZE);

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              cpu_rstn_q, cpu_rstn_d;
    logic              cpu_clk_en_q, cpu_clk_en_d;
    logic              halted_q, halted_d;
    logic [15:0]       halt_ip_q, halt_ip_d;

    logic              in_ready_w;
    logic              byte_accept_w;
    logic              word_done_w;
    logic              word_last_w;
    logic [31:0]       word_w;

    assign in_ready_w    = (state_q == S_LOAD);
    // A coincident restart drops the byte even though in_ready was high.
    assign byte_accept_w = bus.in_valid && in_ready_w && !restart;

    byte_packer u_byte_packer (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .accept    (byte_accept_w),
        .in_data   (bus.in_data),
        .in_last   (bus.in_last),
        .word_done (word_done_w),
        .word_last (word_last_w),
        .word      (word_w)
    );

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        hold_cnt_d  = hold_cnt_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        halted_d    = halted_q;
        halt_ip_d   = halt_ip_q;

        if (restart) begin
            state_d    = S_LOAD;
            waddr_d    = '0;
            hold_cnt_d = '0;
            halted_d   = 1'b0;
            halt_ip_d  = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (word_done_w) begin
                        rom_we_d    = 1'b1;
                        rom_waddr_d = waddr_q;
                        rom_wdata_d = word_w;
                        waddr_d     = waddr_q + ADDR_W'(1);
                        if (waddr_q == LAST_ADDR) begin
                            state_d = S_HOLD;
                        end else if (word_last_w) begin
                            state_d = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    rom_we_d    = 1'b1;
                    rom_waddr_d = waddr_q;
                    rom_wdata_d = '0;
                    waddr_d     = waddr_q + ADDR_W'(1);
                    if (waddr_q == LAST_ADDR) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The final-write cycle is hold count 0; RESET_HOLD more follow.
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if ({1'b0, bus.ip} >= IP_LIMIT) begin
                        state_d   = S_HALT;
                        halted_d  = 1'b1;
                        halt_ip_d = bus.ip;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end

        cpu_rstn_d   = (state_d == S_RUN) || (state_d == S_HALT);
        cpu_clk_en_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            waddr_q      <= '0;
            hold_cnt_q   <= '0;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            cpu_rstn_q   <= 1'b0;
            cpu_clk_en_q <= 1'b0;
            halted_q     <= 1'b0;
            halt_ip_q    <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            hold_cnt_q   <= hold_cnt_d;
            rom_we_q     <= rom_we_d;
            rom_waddr_q  <= rom_waddr_d;
            rom_wdata_q  <= rom_wdata_d;
            cpu_rstn_q   <= cpu_rstn_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            halted_q     <= halted_d;
            halt_ip_q    <= halt_ip_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_waddr  = rom_waddr_q;
    assign bus.rom_wdata  = rom_wdata_q;
    assign bus.cpu_rstn   = cpu_rstn_q;
    assign bus.cpu_clk_en = cpu_clk_en_q;
    assign bus.halted     = halted_q;
    assign bus.halt_ip    = halt_ip_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_sequencer
// Purpose  : Self-checking bench for boot_sequencer with a ROM-write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_boot_sequencer;

    localparam int ROM_SIZE   = 4;
    localparam int RESET_HOLD = 2;
    localparam int AW         = $clog2(ROM_SIZE);

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;

    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] src[$];
    bit   rstn_high_in_load;

    boot_sequencer_if #(.ROM_SIZE(ROM_SIZE)) bif ();

    boot_sequencer #(
        .ROM_SIZE   (ROM_SIZE),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard: every ROM write must match the next expected write.
    always @(negedge clk) begin
        if (bif.rom_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rom_write_unexpected got=%0d:%h required=none", bif.rom_waddr, bif.rom_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bif.rom_waddr !== mon_e.addr || bif.rom_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL rom_write got=%0d:%h required=%0d:%h",
                             bif.rom_waddr, bif.rom_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last);
        int n = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_last  = last;
        while (bif.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_byte_timeout got=in_ready_low required=in_ready_high");
        end
        if (bif.cpu_rstn !== 1'b0) rstn_high_in_load = 1'b1;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    // Builds expected writes for src[] (zero fill after in_last), then sends it.
    task automatic load_stream(input bit use_last, input bit gap);
        logic [31:0] w = '0;
        int k = 0;
        int a = 0;
        wr_t e;
        for (int i = 0; i < src.size(); i++) begin
            w[8*k +: 8] = src[i];
            k++;
            if (k == 4 || (use_last && i == src.size() - 1)) begin
                e.addr = AW'(a); e.data = w;
                exp_q.push_back(e);
                a++; w = '0; k = 0;
            end
        end
        while (a < ROM_SIZE) begin
            e.addr = AW'(a); e.data = '0;
            exp_q.push_back(e);
            a++;
        end
        rstn_high_in_load = 1'b0;
        for (int i = 0; i < src.size(); i++) begin
            if (gap && i > 0) begin
                @(posedge clk); #1;
            end
            send_byte(src[i], use_last && (i == src.size() - 1));
        end
        total++;
        if (rstn_high_in_load !== 1'b0) begin
            bad++;
            $display("FAIL rstn_during_load got=1 required=0");
        end
    endtask

    // Called in the cycle the final ROM write is visible.
    task automatic wait_run();
        int n = 0;
        bit early = 1'b0;
        total++;
        if (bif.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL in_ready_after_load got=%b required=0", bif.in_ready);
        end
        while (bif.cpu_clk_en !== 1'b1 && n < 50) begin
            if (bif.cpu_rstn !== 1'b0) early = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != RESET_HOLD + 1) begin
            bad++;
            $display("FAIL hold_cycles got=%0d required=%0d", n, RESET_HOLD + 1);
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL rstn_early got=1 required=0");
        end
        total++;
        if (bif.cpu_rstn !== 1'b1) begin
            bad++;
            $display("FAIL rstn_in_run got=%b required=1", bif.cpu_rstn);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        total++;
        if (bif.halted !== 1'b0 || bif.cpu_rstn !== 1'b0 || bif.cpu_clk_en !== 1'b0 || bif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_state got=h%b r%b e%b rdy%b required=h0 r0 e0 rdy1",
                     bif.halted, bif.cpu_rstn, bif.cpu_clk_en, bif.in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        total++;
        if (bif.in_ready !== 1'b1 || bif.rom_we !== 1'b0 || bif.rom_waddr !== '0 || bif.rom_wdata !== 32'h0 ||
            bif.cpu_rstn !== 1'b0 || bif.cpu_clk_en !== 1'b0 || bif.halted !== 1'b0 || bif.halt_ip !== 16'h0) begin
            bad++;
            $display("FAIL reset_values got=rdy%b we%b a%0d d%h r%b e%b h%b hip%h required=rdy1 all_zero",
                     bif.in_ready, bif.rom_we, bif.rom_waddr, bif.rom_wdata,
                     bif.cpu_rstn, bif.cpu_clk_en, bif.halted, bif.halt_ip);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        src.delete();
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        load_stream(1'b0, 1'b0);
        wait_run();
    endtask

    task automatic test_halt();
        int wrong = 0;
        bif.ip = 16'd3;
        repeat (2) begin
            @(posedge clk); #1;
        end
        total++;
        if (bif.halted !== 1'b0 || bif.cpu_clk_en !== 1'b1) begin
            bad++;
            $display("FAIL ip_in_range got=h%b e%b required=h0 e1", bif.halted, bif.cpu_clk_en);
        end
        bif.ip = 16'd4;
        @(posedge clk); #1;
        bif.ip = 16'd0;
        total++;
        if (bif.halted !== 1'b1 || bif.halt_ip !== 16'd4 || bif.cpu_clk_en !== 1'b0 || bif.cpu_rstn !== 1'b1) begin
            bad++;
            $display("FAIL halt_edge got=h%b ip%0d e%b r%b required=h1 ip4 e0 r1",
                     bif.halted, bif.halt_ip, bif.cpu_clk_en, bif.cpu_rstn);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bif.halted !== 1'b1 || bif.cpu_clk_en !== 1'b0 || bif.halt_ip !== 16'd4) wrong++;
        end
        total++;
        if (wrong != 0) begin
            bad++;
            $display("FAIL halt_sticky got=%0d_bad_cycles required=0", wrong);
        end
    endtask

    task automatic test_restart();
        wr_t e;
        do_restart();
        e.addr = '0; e.data = 32'h53525150;
        exp_q.push_back(e);
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
        // A byte coincident with restart must be dropped.
        restart      = 1'b1;
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h99;
        @(posedge clk); #1;
        restart      = 1'b0;
        bif.in_valid = 1'b0;
        total++;
        if (bif.cpu_rstn !== 1'b0 || bif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_mid_load got=r%b rdy%b required=r0 rdy1", bif.cpu_rstn, bif.in_ready);
        end
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(8'hA0 + 8'(i));
        load_stream(1'b0, 1'b0);
        wait_run();
    endtask

    task automatic test_fill();
        do_restart();
        src.delete();
        src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC);
        src.push_back(8'hDD); src.push_back(8'hEE); src.push_back(8'hFF);
        load_stream(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bif.rom_we !== 1'b1) begin
                bad++;
                $display("FAIL fill_consecutive cycle=%0d got=%b required=1", i, bif.rom_we);
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        wait_run();
    endtask

    task automatic test_back_to_back_gapped();
        do_restart();
        src.delete();
        for (int i = 1; i <= 16; i++) src.push_back(8'(i));
        load_stream(1'b0, 1'b1);
        wait_run();
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (bif.cpu_rstn !== 1'b0 || bif.cpu_clk_en !== 1'b0 || bif.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset got=r%b e%b rdy%b required=r0 e0 rdy1",
                     bif.cpu_rstn, bif.cpu_clk_en, bif.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        bif.in_last  = 1'b0;
        bif.ip       = 16'h0000;
        test_reset();
        test_full_load();
        test_halt();
        test_restart();
        test_fill();
        test_back_to_back_gapped();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
